// File: rtl/instr_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit and the decoder:
// instruction size codes, opcode low-nibble classes and the length decode.
`timescale 1ns/1ps
package instr_prefetch_pkg;

    localparam logic [1:0] SIZE_1 = 2'd1;
    localparam logic [1:0] SIZE_2 = 2'd2;
    localparam logic [1:0] SIZE_3 = 2'd3;

    localparam logic [3:0] NIB_4 = 4'h4;
    localparam logic [3:0] NIB_7 = 4'h7;
    localparam logic [3:0] NIB_D = 4'hD;
    localparam logic [3:0] NIB_E = 4'hE;
    localparam logic [3:0] NIB_F = 4'hF;

    function automatic logic [1:0] instrLen(input logic [7:0] opcode);
        logic [3:0] lo;
        lo = opcode[3:0];
        if (lo == NIB_E || lo == NIB_F)
            return SIZE_1;
        if ((lo >= NIB_4 && lo <= NIB_7) || lo == NIB_D)
            return SIZE_3;
        return SIZE_2;
    endfunction

endpackage

// File: rtl/instr_prefetch_queue.sv
// Circular byte buffer: one push per cycle, pop of 0..3 bytes, three-byte
// peek at the head and an occupancy count. DEPTH must be a power of two.
`timescale 1ns/1ps
module prefetch_queue #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    pushData,
    input  logic          pop,
    input  logic [1:0]    popCount,
    output logic [7:0]    head0,
    output logic [7:0]    head1,
    output logic [7:0]    head2,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] popAmt;

    assign popAmt = pop ? PW'(popCount) : '0;

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + PW'(1);
            rdPtr <= rdPtr + popAmt;
            count <= count + CW'(push) - CW'(popAmt);
        end
    end

    // Storage needs no reset; stale bytes are never visible past count.
    always_ff @(posedge clk) begin
        if (reset_n && !flush && push)
            mem[wrPtr] <= pushData;
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign head0 = mem[rdPtr];
    assign head1 = mem[rdPtr + PW'(1)];
    assign head2 = mem[rdPtr + PW'(2)];

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: streams program bytes into a small queue and hands
// complete 1/2/3-byte instructions to the decoder; redirects flush and refetch.
`timescale 1ns/1ps
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memStrobe,
    input  logic [7:0]            memDataRead,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirectAddr,
    output logic                  instrValid,
    input  logic                  instrReady,
    output logic [23:0]           instrBytes,
    output logic [1:0]            instrSize,
    output logic [ADDR_WIDTH-1:0] instrPc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] fetchPc;
    logic                  inflight;
    logic [CW-1:0]         count;
    logic [7:0]            head0, head1, head2;
    logic                  push;
    logic                  pop;

    // A redirect in the return cycle kills the byte from the older stream.
    assign push = reset_n && !redirect && inflight;

    // Counting the in-flight byte as occupied keeps the queue from overflowing.
    assign memStrobe = reset_n && !redirect && ((count + CW'(inflight)) < CW'(DEPTH));
    assign memAddr   = fetchPc;

    assign instrSize  = instrLen(head0);
    assign instrValid = reset_n && !redirect && (count != '0) && (count >= CW'(instrSize));
    assign instrBytes = {head0,
                         (instrSize != SIZE_1) ? head1 : 8'h00,
                         (instrSize == SIZE_3) ? head2 : 8'h00};
    assign pop = instrValid && instrReady;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetchPc  <= RESET_PC;
            instrPc  <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect) begin
            fetchPc  <= redirectAddr;
            instrPc  <= redirectAddr;
            inflight <= 1'b0;
        end else begin
            inflight <= memStrobe;
            if (memStrobe)
                fetchPc <= fetchPc + ADDR_WIDTH'(1);
            if (pop)
                instrPc <= instrPc + ADDR_WIDTH'(instrSize);
        end
    end

    prefetch_queue #(.DEPTH(DEPTH)) queue (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (redirect),
        .push     (push),
        .pushData (memDataRead),
        .pop      (pop),
        .popCount (instrSize),
        .head0    (head0),
        .head1    (head1),
        .head2    (head2),
        .count    (count)
    );

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: opcode table, latency/corner sequences, random
// traffic against a byte-stream reference model, and an 8-bit wrap instance.
`timescale 1ns/1ps
module tb_instr_prefetch;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, redirect, instrReady, memStrobe, instrValid;
    logic [15:0] memAddr, redirectAddr, instrPc;
    logic [7:0]  memDataRead;
    logic [23:0] instrBytes;
    logic [1:0]  instrSize;

    logic        reset8_n, redirect8, instrReady8, memStrobe8, instrValid8;
    logic [7:0]  memAddr8, redirectAddr8, instrPc8, memDataRead8;
    logic [23:0] instrBytes8;
    logic [1:0]  instrSize8;

    instr_prefetch #(.ADDR_WIDTH(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n), .memAddr(memAddr), .memStrobe(memStrobe),
        .memDataRead(memDataRead), .redirect(redirect), .redirectAddr(redirectAddr),
        .instrValid(instrValid), .instrReady(instrReady), .instrBytes(instrBytes),
        .instrSize(instrSize), .instrPc(instrPc));

    instr_prefetch #(.ADDR_WIDTH(8), .DEPTH(DEPTH), .RESET_PC(8'hFC)) dut8 (
        .clk(clk), .reset_n(reset8_n), .memAddr(memAddr8), .memStrobe(memStrobe8),
        .memDataRead(memDataRead8), .redirect(redirect8), .redirectAddr(redirectAddr8),
        .instrValid(instrValid8), .instrReady(instrReady8), .instrBytes(instrBytes8),
        .instrSize(instrSize8), .instrPc(instrPc8));

    logic [7:0] mem  [65536];
    logic [7:0] mem8 [256];

    // Program memory: one-cycle read latency; garbage when no strobe was issued.
    always @(posedge clk) memDataRead  <= memStrobe  ? mem[memAddr]   : 8'($urandom);
    always @(posedge clk) memDataRead8 <= memStrobe8 ? mem8[memAddr8] : 8'($urandom);

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Instruction length by opcode low nibble.
    int lenTab [16] = '{2, 2, 2, 2, 3, 3, 3, 3, 2, 2, 2, 2, 2, 3, 1, 1};
    function automatic int lenOf(input logic [7:0] op);
        return lenTab[op[3:0]];
    endfunction

    // Reference model: the byte stream seen from the program counter.
    logic [15:0] mPc, mFetch;
    int          outstanding;   // bytes requested since last flush, not yet consumed
    int          prevStrobe;    // a byte still on its way back from memory
    bit          known = 0;
    int          xfers = 0;

    logic        sStrobe, sValid;
    logic [15:0] sAddr, sPc;
    logic [1:0]  sSize;
    logic [23:0] sBytes;

    task automatic cycle(input logic rst, input logic rd, input logic [15:0] ra, input logic rdy);
        bit          expStrobe, expValid;
        int          len;
        logic [23:0] eb;
        @(negedge clk);
        reset_n = rst; redirect = rd; redirectAddr = ra; instrReady = rdy;
        #1;
        expStrobe = rst && !rd && (outstanding < DEPTH);
        check("memStrobe", memStrobe, expStrobe);
        if (memStrobe && expStrobe) check("memAddr", memAddr, mFetch);
        len = lenOf(mem[mPc]);
        expValid = rst && !rd && ((outstanding - prevStrobe) >= len);
        check("instrValid", instrValid, expValid);
        if (known) check("instrPc", instrPc, mPc);
        if (instrValid && expValid) begin
            eb = {mem[mPc],
                  len > 1 ? mem[16'(mPc + 16'd1)] : 8'h00,
                  len > 2 ? mem[16'(mPc + 16'd2)] : 8'h00};
            check("instrSize", instrSize, len);
            check("instrBytes", instrBytes, eb);
        end
        sStrobe = memStrobe; sAddr = memAddr; sValid = instrValid;
        sPc = instrPc; sSize = instrSize; sBytes = instrBytes;
        if (!rst) begin
            mPc = 16'h0000; mFetch = 16'h0000; outstanding = 0; prevStrobe = 0; known = 1;
        end else if (rd) begin
            mPc = ra; mFetch = ra; outstanding = 0; prevStrobe = 0;
        end else begin
            prevStrobe = expStrobe;
            if (expStrobe) begin mFetch = mFetch + 16'd1; outstanding++; end
            if (expValid && rdy) begin
                mPc = 16'(mPc + 16'(len)); outstanding -= len; xfers++;
            end
        end
    endtask

    // Cycles (1-based) until instrValid is seen; -1 if the bound expires.
    task automatic waitValid(input int maxCyc, input logic rdy, output int offs);
        offs = -1;
        for (int i = 1; i <= maxCyc; i++) begin
            cycle(1'b1, 1'b0, 16'h0, rdy);
            if (sValid) begin offs = i; break; end
        end
        if (offs < 0) check("waitValid_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [1:0]  size;
        logic [23:0] bytes;
    } vec_t;
    vec_t vecs [10];

    int          offs, strobes;
    logic [15:0] capPc  [8];
    logic [1:0]  capSz  [8];
    logic [23:0] capBy  [8];
    logic [7:0]  strAd  [8];
    int          nCap, nStr;

    initial begin
        reset_n = 1'b0; redirect = 1'b0; redirectAddr = '0; instrReady = 1'b0;
        reset8_n = 1'b0; redirect8 = 1'b0; redirectAddr8 = '0; instrReady8 = 1'b0;
        mPc = '0; mFetch = '0; outstanding = 0; prevStrobe = 0;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0000] = 8'hFF; mem[16'h0001] = 8'hFF; mem[16'h0002] = 8'hFF;
        mem[16'h0100] = 8'h0C; mem[16'h0101] = 8'h42; mem[16'h0102] = 8'hE6;
        mem[16'h0103] = 8'h10; mem[16'h0104] = 8'h05;
        for (int i = 0; i < 16; i++) mem[16'h0300 + i] = 8'hAA;
        mem[16'h0040] = 8'hFF; mem[16'h0041] = 8'hFF;

        vecs[0] = '{8'h00, 2'd2, 24'h001100};
        vecs[1] = '{8'h13, 2'd2, 24'h131100};
        vecs[2] = '{8'h24, 2'd3, 24'h241122};
        vecs[3] = '{8'h37, 2'd3, 24'h371122};
        vecs[4] = '{8'h48, 2'd2, 24'h481100};
        vecs[5] = '{8'h5C, 2'd2, 24'h5C1100};
        vecs[6] = '{8'h6D, 2'd3, 24'h6D1122};
        vecs[7] = '{8'h7E, 2'd1, 24'h7E0000};
        vecs[8] = '{8'h8F, 2'd1, 24'h8F0000};
        vecs[9] = '{8'h95, 2'd3, 24'h951122};
        for (int i = 0; i < 10; i++) begin
            mem[16'h2000 + 16'(i * 4)]     = vecs[i].op;
            mem[16'h2000 + 16'(i * 4) + 1] = 8'h11;
            mem[16'h2000 + 16'(i * 4) + 2] = 8'h22;
        end

        // Reset, release, first nops.
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check("rst_valid", sValid, 1'b0);
        check("rst_strobe", sStrobe, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        check("first_strobe", sStrobe, 1'b1);
        check("first_addr", sAddr, 16'h0000);
        waitValid(8, 1'b1, offs);
        check("first_latency", offs, 2);
        check("nop0_pc", sPc, 16'h0000);
        check("nop0_bytes", sBytes, 24'hFF0000);
        check("nop0_size", sSize, 2'd1);
        waitValid(8, 1'b1, offs);
        check("nop1_pc", sPc, 16'h0001);

        // Stream 0C 42 E6 10 05.
        cycle(1'b1, 1'b1, 16'h0100, 1'b1);
        waitValid(8, 1'b1, offs);
        check("s2_pc0", sPc, 16'h0100);
        check("s2_by0", sBytes, 24'h0C4200);
        check("s2_sz0", sSize, 2'd2);
        waitValid(8, 1'b1, offs);
        check("s2_pc1", sPc, 16'h0102);
        check("s2_by1", sBytes, 24'hE61005);
        check("s2_sz1", sSize, 2'd3);

        // Back-pressure: strobes stop at DEPTH, then resume.
        cycle(1'b1, 1'b1, 16'h0100, 1'b0);
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 16'h0, 1'b0);
            strobes += int'(sStrobe);
        end
        check("bp_strobes", strobes, DEPTH);
        waitValid(4, 1'b1, offs);
        check("bp_resume_lat", offs, 1);
        check("bp_pc", sPc, 16'h0100);
        check("bp_bytes", sBytes, 24'h0C4200);
        waitValid(8, 1'b1, offs);
        check("bp_pc2", sPc, 16'h0102);

        // Redirect while a stale byte (0xAA) is in flight.
        cycle(1'b1, 1'b1, 16'h0300, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        check("aa_strobe", sStrobe, 1'b1);
        cycle(1'b1, 1'b1, 16'h0040, 1'b1);
        waitValid(8, 1'b1, offs);
        check("redir_latency", offs, 3);
        check("redir_pc", sPc, 16'h0040);
        check("redir_op", sBytes[23:16], 8'hFF);

        // Back-to-back redirects: last wins.
        cycle(1'b1, 1'b1, 16'h0300, 1'b1);
        cycle(1'b1, 1'b1, 16'h0100, 1'b1);
        waitValid(8, 1'b1, offs);
        check("b2b_pc", sPc, 16'h0100);

        // Opcode length table.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 16'h2000 + 16'(i * 4), 1'b0);
            waitValid(8, 1'b0, offs);
            check("tbl_size", sSize, vecs[i].size);
            check("tbl_bytes", sBytes, vecs[i].bytes);
        end

        // Reset with a full queue.
        cycle(1'b1, 1'b1, 16'h0100, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        check("rstfull_valid", sValid, 1'b0);
        check("rstfull_pc", sPc, 16'h0000);
        check("rstfull_addr", sAddr, 16'h0000);

        // Random traffic against the model.
        xfers = 0;
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 199) != 0, $urandom_range(0, 29) == 0,
                  16'($urandom), $urandom_range(0, 9) < 7);
        check("rand_progress", xfers > 200, 1'b1);

        // 8-bit address instance: wrap across 0xFF.
        mem8[8'hFC] = 8'hFF; mem8[8'hFD] = 8'hFF; mem8[8'hFE] = 8'h04;
        mem8[8'hFF] = 8'h11; mem8[8'h00] = 8'h22; mem8[8'h01] = 8'h0E;
        mem8[8'h02] = 8'h0E; mem8[8'h03] = 8'h0E; mem8[8'h04] = 8'h0E;
        mem8[8'h05] = 8'h0E; mem8[8'h06] = 8'h0E; mem8[8'h07] = 8'h0E;
        @(negedge clk); reset8_n = 1'b0;
        @(negedge clk); reset8_n = 1'b1; instrReady8 = 1'b1;
        nCap = 0; nStr = 0;
        for (int i = 0; i < 30 && nCap < 4; i++) begin
            #1;
            if (memStrobe8 && nStr < 6) begin strAd[nStr] = memAddr8; nStr++; end
            if (instrValid8) begin
                capPc[nCap] = 16'(instrPc8); capSz[nCap] = instrSize8;
                capBy[nCap] = instrBytes8; nCap++;
            end
            @(negedge clk);
        end
        check("w8_captures", nCap, 4);
        check("w8_strobes", nStr >= 6, 1'b1);
        if (nStr >= 6) begin
            check("w8_addr3", strAd[3], 8'hFF);
            check("w8_addr4", strAd[4], 8'h00);
            check("w8_addr5", strAd[5], 8'h01);
        end
        if (nCap == 4) begin
            check("w8_pc0", capPc[0], 16'h00FC);
            check("w8_pc1", capPc[1], 16'h00FD);
            check("w8_pc2", capPc[2], 16'h00FE);
            check("w8_sz2", capSz[2], 2'd3);
            check("w8_by2", capBy[2], 24'h041122);
            check("w8_pc3", capPc[3], 16'h0001);
            check("w8_by3", capBy[3], 24'h0E0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_prefetch.md
Name: instr_prefetch

Overview:
Parametrised instruction prefetch unit between the program memory and the Z8-style decoder. It replaces the fixed fetch/wait/read sequence with continuous byte fetching into a small queue. It decodes instruction length from the opcode and presents complete 1/2/3-byte instructions over a valid/ready handshake. Branch redirects flush the queue and restart fetching at a new address.

Parameters:
ADDR_WIDTH, 16, width of program address and PC; all PC arithmetic is modulo 2^ADDR_WIDTH.
DEPTH, 4, byte queue capacity; power of two, minimum 4.
RESET_PC, 0, fetch/instruction address after reset.

Ports:
clk  in  1  clock, all state updates on posedge
reset_n  in  1  synchronous active-low reset
memAddr  out  ADDR_WIDTH  program memory read address
memStrobe  out  1  read request; memory returns data on memDataRead the following cycle
memDataRead  in  8  read data for the strobe issued one cycle earlier
redirect  in  1  branch taken; flush and refetch
redirectAddr  in  ADDR_WIDTH  new PC, sampled when redirect=1
instrValid  out  1  complete instruction at queue head
instrReady  in  1  decoder accepts instruction
instrBytes  out  24  {opcode, second, third}; bytes beyond instrSize read as 0
instrSize  out  2  1, 2 or 3
instrPc  out  ADDR_WIDTH  address of opcode byte

Behaviour:
- Reset (reset_n=0 at posedge): fetchPc=instrPc=RESET_PC, queue empty, in-flight flag clear. memStrobe=0 and instrValid=0 while reset_n=0.
- Length decode on opcode low nibble L: L=E or F -> 1; L in 4..7 or L=D -> 3; otherwise 2.
- Fetch: memStrobe=1 iff reset_n=1, redirect=0, and count + inflight < DEPTH. memAddr=fetchPc. Each strobe sets inflight for the next cycle and increments fetchPc, wrapping.
- Return: the cycle after a strobe, memDataRead is pushed at the tail unless a redirect occurred in that cycle. Data from a strobe issued before a redirect is discarded.
- Invariant: count + inflight <= DEPTH; the queue never overflows. Sustained throughput is one byte per cycle.
- Output: instrValid=1 iff redirect=0 and count >= size(head). instrBytes and instrSize are combinational from the queue head. instrPc is a register.
- Transfer on instrValid & instrReady: pop instrSize bytes and add instrSize to instrPc (wrapping), in the same cycle. Push and pop may occur together; the count update is count + push - pop.
- Redirect (priority over everything except reset):
  - At that posedge: queue flushed, inflight data dropped, fetchPc=instrPc=redirectAddr.
  - No strobe and no transfer in the redirect cycle.
  - With redirect at cycle t: strobe at t+1 (addr redirectAddr), byte queued at end of t+2, earliest instrValid at t+3.
- Back-to-back redirects: the last one wins.
- Reset mid-fetch: in-flight data is dropped, same as a redirect.
- Empty queue: instrValid=0 and outputs hold don't-care values, except instrPc, which holds.
- instrReady with instrValid=0 has no effect.

Decomposition:
- Shared package: length-decode function, instruction-size constants (SIZE_1/2/3), and opcode low-nibble constants. The existing processor decoder imports the same function.
- One sub-module, prefetch_queue: DEPTH x 8 circular byte buffer with single push, multi-pop of 1..3, three-byte head peek, and occupancy count.

Test Plan:
- Reset then release; memory holds FF,FF at 0: strobe addr 0 at cycle 1. Output nop (FF, size 1, instrPc 0) at cycle 3, next nop at instrPc 1.
- Memory 0C 42 E6 10 05 with instrReady=1: outputs {0C,42,00} size 2 pc 0, then {E6,10,05} size 3 pc 2.
- instrReady=0 for 10 cycles: strobes stop when count+inflight=DEPTH (4), no byte lost, then stream resumes correctly.
- Redirect to 0x0040 while a strobe is in flight (returning 0xAA): 0xAA never appears. First instrPc is 0x0040 three cycles later.
- ADDR_WIDTH=8, stream crossing 0xFF: fetchPc wraps to 0x00. A 3-byte instruction at 0xFE has instrPc 0xFE, next instrPc 0x01.
- reset_n low during full queue: instrValid=0 the next cycle, restart from RESET_PC.
